// File: rtl/instr_exec_unit_if.sv
// Shared instruction-register types and the read/result bus of instr_exec_unit.
// master = execution unit (drives read_pointer and results), slave = register/consumer side.
package instr_register_pkg;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

interface instr_exec_unit_if #(parameter int RES_W = 64);
  import instr_register_pkg::*;

  address_t                 read_pointer;
  instruction_t             instruction_word;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [RES_W-1:0]  res_data;
  opcode_t                  res_opc;
  address_t                 res_addr;
  logic                     res_err;

  modport master (
    output read_pointer,
    input  instruction_word,
    output res_valid,
    input  res_ready,
    output res_data,
    output res_opc,
    output res_addr,
    output res_err
  );

  modport slave (
    input  read_pointer,
    output instruction_word,
    input  res_valid,
    output res_ready,
    input  res_data,
    input  res_opc,
    input  res_addr,
    input  res_err
  );
endinterface

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a wrapping window of instruction slots, executes each and hands out results.
// Optional divider enabled by defining INSTR_EXEC_DIVIDE_EN; otherwise DIV/MOD report an error.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int RES_W = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  address_t           first_addr,
  input  logic [5:0]         count,
  output logic               busy,
  output logic               done,
  instr_exec_unit_if.master  bus
);

  // state | meaning
  // IDLE  | waiting for start; count=0 start only pulses done
  // FETCH | capture instruction_word at read_pointer
  // EXEC  | compute result into output registers
  // OUT   | hold result until res_valid && res_ready
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, OUT} state_t;

  state_t                   state;
  address_t                 read_pointer;
  logic [5:0]               remaining;
  instruction_t             hold_instr;
  address_t                 hold_addr;
  logic                     res_valid;
  logic signed [RES_W-1:0]  res_data;
  opcode_t                  res_opc;
  address_t                 res_addr;
  logic                     res_err;

  logic signed [RES_W-1:0]  a_ext;
  logic signed [RES_W-1:0]  b_ext;
  logic signed [RES_W-1:0]  exec_data;
  logic                     exec_err;

  assign bus.read_pointer = read_pointer;
  assign bus.res_valid    = res_valid;
  assign bus.res_data     = res_data;
  assign bus.res_opc      = res_opc;
  assign bus.res_addr     = res_addr;
  assign bus.res_err      = res_err;

  always_comb begin
    a_ext     = {{(RES_W-32){hold_instr.op_a[31]}}, hold_instr.op_a};
    b_ext     = {{(RES_W-32){hold_instr.op_b[31]}}, hold_instr.op_b};
    exec_data = '0;
    exec_err  = 1'b0;
    case (hold_instr.opc)
      ZERO:  exec_data = '0;
      PASSA: exec_data = a_ext;
      PASSB: exec_data = b_ext;
      ADD:   exec_data = a_ext + b_ext;
      SUB:   exec_data = a_ext - b_ext;
      MULT:  exec_data = a_ext * b_ext;
`ifdef INSTR_EXEC_DIVIDE_EN
      // Division at RES_W so -2^31 / -1 yields +2^31 without overflow.
      DIV: begin
        if (b_ext == '0) exec_err  = 1'b1;
        else             exec_data = a_ext / b_ext;
      end
      MOD: begin
        if (b_ext == '0) exec_err  = 1'b1;
        else             exec_data = a_ext % b_ext;
      end
`endif
      default: exec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      read_pointer <= '0;
      remaining    <= '0;
      hold_instr   <= '0;
      hold_addr    <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_opc      <= ZERO;
      res_addr     <= '0;
      res_err      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != 6'd0) begin
              read_pointer <= first_addr;
              remaining    <= count;
              busy         <= 1'b1;
              state        <= FETCH;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          hold_instr <= bus.instruction_word;
          hold_addr  <= read_pointer;
          state      <= EXEC;
        end
        EXEC: begin
          res_data  <= exec_data;
          res_err   <= exec_err;
          res_opc   <= hold_instr.opc;
          res_addr  <= hold_addr;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_valid && bus.res_ready) begin
            res_valid <= 1'b0;
            if (remaining == 6'd1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              // 5-bit pointer wraps 31 -> 0 naturally.
              read_pointer <= read_pointer + 5'd1;
              remaining    <= remaining - 6'd1;
              state        <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed self-checking bench for instr_exec_unit; expectations follow INSTR_EXEC_DIVIDE_EN.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  address_t   first_addr;
  logic [5:0] count;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fails  = 0;

  instruction_t mem [32];

  instr_exec_unit_if #(.RES_W(64)) bus ();

  instr_exec_unit #(.RES_W(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  always_comb bus.instruction_word = mem[bus.read_pointer];

  function automatic instruction_t mk(logic [3:0] o, int a, int b);
    instruction_t t;
    t.opc  = opcode_t'(o);
    t.op_a = a;
    t.op_b = b;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(string tag, logic [63:0] exp_data, logic [3:0] exp_opc,
                             logic [4:0] exp_addr, logic exp_err);
    for (int i = 0; i < 12 && bus.res_valid !== 1'b1; i++) tick();
    chk({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
    chk({tag, "_data"},  bus.res_data,       exp_data);
    chk({tag, "_opc"},   64'(bus.res_opc),   64'(exp_opc));
    chk({tag, "_addr"},  64'(bus.res_addr),  64'(exp_addr));
    chk({tag, "_err"},   64'(bus.res_err),   64'(exp_err));
    chk({tag, "_rp"},    64'(bus.read_pointer), 64'(exp_addr));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0]  = mk(4'd3, 5, -7);
    mem[1]  = mk(4'd5, -3, 100000);
    mem[30] = mk(4'd4, 10, 3);
    mem[31] = mk(4'd1, -4, 9);
    mem[4]  = mk(4'd2, 1, -55);
    mem[5]  = mk(4'd0, 3, 4);
    mem[8]  = mk(4'd9, 1, 2);
    mem[9]  = mk(4'd6, 7, 0);
    mem[10] = mk(4'd6, -7, 2);
    mem[11] = mk(4'd7, -7, 2);
    mem[12] = mk(4'd6, 32'sh8000_0000, -1);
    mem[16] = mk(4'd3, 1, 1);
    mem[17] = mk(4'd3, 2, 2);
    mem[18] = mk(4'd3, 3, 3);
    mem[20] = mk(4'd1, 11, 0);

    reset_n = 1'b0; start = 1'b0; first_addr = '0; count = '0;
    bus.res_ready = 1'b1;
    tick(); tick();
    chk("rst_rp",    64'(bus.read_pointer), 64'd0);
    chk("rst_valid", 64'(bus.res_valid),    64'd0);
    chk("rst_data",  bus.res_data,          64'd0);
    chk("rst_opc",   64'(bus.res_opc),      64'd0);
    chk("rst_addr",  64'(bus.res_addr),     64'd0);
    chk("rst_err",   64'(bus.res_err),      64'd0);
    chk("rst_busy",  64'(busy),             64'd0);
    chk("rst_done",  64'(done),             64'd0);
    reset_n = 1'b1;
    tick();

    // Two-instruction run with exact latency checks.
    start = 1'b1; first_addr = 5'd0; count = 6'd2;
    tick();
    start = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_rp0",  64'(bus.read_pointer), 64'd0);
    tick();
    chk("t1_notyet", 64'(bus.res_valid), 64'd0);
    tick();
    chk("t1_lat", 64'(bus.res_valid), 64'd1);
    wait_result("t1_r0", -64'sd2, 4'd3, 5'd0, 1'b0);
    tick();
    chk("t1_hs_valid", 64'(bus.res_valid), 64'd0);
    chk("t1_hs_done",  64'(done), 64'd0);
    chk("t1_rp1",      64'(bus.read_pointer), 64'd1);
    wait_result("t1_r1", -64'sd300000, 4'd5, 5'd1, 1'b0);
    tick();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_idle", 64'(busy), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);

    // Wrapping window 30,31,0,1.
    start = 1'b1; first_addr = 5'd30; count = 6'd4;
    tick();
    start = 1'b0;
    wait_result("t2_r0", 64'd7, 4'd4, 5'd30, 1'b0);
    tick();
    wait_result("t2_r1", -64'sd4, 4'd1, 5'd31, 1'b0);
    tick();
    wait_result("t2_r2", -64'sd2, 4'd3, 5'd0, 1'b0);
    tick();
    wait_result("t2_r3", -64'sd300000, 4'd5, 5'd1, 1'b0);
    tick();
    chk("t2_done", 64'(done), 64'd1);

    // Back-pressure: outputs frozen while res_ready is low.
    bus.res_ready = 1'b0;
    start = 1'b1; first_addr = 5'd4; count = 6'd2;
    tick();
    start = 1'b0;
    wait_result("t3_r0", -64'sd55, 4'd2, 5'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall_valid", 64'(bus.res_valid), 64'd1);
      chk("t3_stall_data",  bus.res_data, -64'sd55);
      chk("t3_stall_rp",    64'(bus.read_pointer), 64'd4);
      chk("t3_stall_done",  64'(done), 64'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    chk("t3_release", 64'(bus.res_valid), 64'd0);
    wait_result("t3_r1", 64'd0, 4'd0, 5'd5, 1'b0);
    tick();
    chk("t3_done", 64'(done), 64'd1);

    // Illegal opcode and divide cases.
    start = 1'b1; first_addr = 5'd8; count = 6'd5;
    tick();
    start = 1'b0;
    wait_result("t4_op9", 64'd0, 4'd9, 5'd8, 1'b1);
    tick();
`ifdef INSTR_EXEC_DIVIDE_EN
    wait_result("t4_div0",  64'd0,          4'd6, 5'd9,  1'b1);
    tick();
    wait_result("t4_div",   -64'sd3,        4'd6, 5'd10, 1'b0);
    tick();
    wait_result("t4_mod",   -64'sd1,        4'd7, 5'd11, 1'b0);
    tick();
    wait_result("t4_divmin", 64'h8000_0000, 4'd6, 5'd12, 1'b0);
`else
    wait_result("t4_div0",  64'd0, 4'd6, 5'd9,  1'b1);
    tick();
    wait_result("t4_div",   64'd0, 4'd6, 5'd10, 1'b1);
    tick();
    wait_result("t4_mod",   64'd0, 4'd7, 5'd11, 1'b1);
    tick();
    wait_result("t4_divmin", 64'd0, 4'd6, 5'd12, 1'b1);
`endif
    tick();
    chk("t4_done", 64'(done), 64'd1);

    // Reset during EXEC of the second of three instructions.
    start = 1'b1; first_addr = 5'd16; count = 6'd3;
    tick();
    start = 1'b0;
    wait_result("t5_r0", 64'd2, 4'd3, 5'd16, 1'b0);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_rst_rp",    64'(bus.read_pointer), 64'd0);
    chk("t5_rst_valid", 64'(bus.res_valid),    64'd0);
    chk("t5_rst_data",  bus.res_data,          64'd0);
    chk("t5_rst_opc",   64'(bus.res_opc),      64'd0);
    chk("t5_rst_addr",  64'(bus.res_addr),     64'd0);
    chk("t5_rst_busy",  64'(busy),             64'd0);
    chk("t5_rst_done",  64'(done),             64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_quiet_done",  64'(done), 64'd0);
      chk("t5_quiet_valid", 64'(bus.res_valid), 64'd0);
    end
    start = 1'b1; first_addr = 5'd17; count = 6'd1;
    tick();
    start = 1'b0;
    wait_result("t5_restart", 64'd4, 4'd3, 5'd17, 1'b0);
    tick();
    chk("t5_done", 64'(done), 64'd1);

    // count=0 pulses done only.
    start = 1'b1; first_addr = 5'd3; count = 6'd0;
    tick();
    start = 1'b0;
    chk("t6_done",  64'(done), 64'd1);
    chk("t6_busy",  64'(busy), 64'd0);
    chk("t6_valid", 64'(bus.res_valid), 64'd0);
    tick();
    chk("t6_done_pulse", 64'(done), 64'd0);
    chk("t6_valid2",     64'(bus.res_valid), 64'd0);

    // Start while busy is ignored.
    start = 1'b1; first_addr = 5'd20; count = 6'd1;
    tick();
    first_addr = 5'd25; count = 6'd5;
    tick();
    start = 1'b0;
    wait_result("t7_r0", 64'd11, 4'd1, 5'd20, 1'b0);
    tick();
    chk("t7_done", 64'(done), 64'd1);
    tick();
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_valid", 64'(bus.res_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
